// File: rtl/tone_gen_poly.sv
// Square-wave tone generator: lowest pressed key wins, octave right-shifts the half period.
// Latency 1 cycle key->speaker high; no backpressure, note/octave changes land on half-period boundaries.
module tone_gen_poly #(
    parameter int NUM_NOTES = 8,
    parameter int CNT_W     = 16,
    parameter int OCT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_NOTES-1:0] key_en,
    input  logic [OCT_W-1:0]     octave,
    output logic                 speaker,
    output logic                 note_active,
    output logic [2:0]           note_idx
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    function automatic logic [CNT_W-1:0] half_period(input logic [2:0] idx);
        case (idx)
            3'd0:    half_period = CNT_W'(47783);
            3'd1:    half_period = CNT_W'(42560);
            3'd2:    half_period = CNT_W'(37925);
            3'd3:    half_period = CNT_W'(35796);
            3'd4:    half_period = CNT_W'(31888);
            3'd5:    half_period = CNT_W'(28409);
            3'd6:    half_period = CNT_W'(25309);
            default: half_period = CNT_W'(23887);
        endcase
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_hp_q, cur_hp_d;
    logic             spk_q, spk_d;
    logic [2:0]       idx_q, idx_d;

    logic [2:0]       sel;
    logic             key_any;
    logic [CNT_W-1:0] hp;
    logic             at_bound;

    // Scan from the top down so the lowest set bit is the last to write sel.
    always_comb begin
        sel = 3'd0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (key_en[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign key_any  = |key_en;
    assign hp       = half_period(sel) >> octave;
    assign at_bound = (cnt_q == (cur_hp_q - CNT_W'(1)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_hp_d = cur_hp_q;
        spk_d    = spk_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                spk_d = 1'b0;
                if (key_any) begin
                    state_d  = S_PLAY;
                    cur_hp_d = hp;
                    idx_d    = sel;
                    spk_d    = 1'b1;
                end
            end
            default: begin
                if (!at_bound) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (key_any) begin
                        spk_d    = ~spk_q;
                        cur_hp_d = hp;
                        idx_d    = sel;
                    end else begin
                        // Release only ever stops on a boundary, so a high phase is never cut short.
                        spk_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cur_hp_q <= '0;
            spk_q    <= 1'b0;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_hp_q <= cur_hp_d;
            spk_q    <= spk_d;
            idx_q    <= idx_d;
        end
    end

    assign speaker     = spk_q;
    assign note_active = (state_q == S_PLAY);
    assign note_idx    = idx_q;

endmodule
